// File: rtl/recovery_ctrl_if.sv
// Branch-resolution / ROB / fetch-redirect bundle for the mispredict recovery controller.
// The master side is the environment (BRUs, ROB, fetch); the slave side is recovery_ctrl.
interface recovery_ctrl_if #(
  parameter int ROB_WIDTH = 4,
  parameter int NUM_BR    = 2
);
  logic [NUM_BR-1:0]           i_br_valid;
  logic [NUM_BR-1:0]           i_br_mispredict;
  logic [NUM_BR*ROB_WIDTH-1:0] i_br_rob_tag;
  logic [NUM_BR*32-1:0]        i_br_target;
  logic [ROB_WIDTH-1:0]        i_rob_head;
  logic                        o_branch_mispredict;
  logic [ROB_WIDTH-1:0]        o_mispredict_rob_tag;
  logic                        o_flush;
  logic                        o_stall_dispatch;
  logic                        o_redirect_valid;
  logic [31:0]                 o_redirect_pc;
  logic                        i_redirect_ready;
  logic [15:0]                 o_recovery_count;

  modport master (
    output i_br_valid, i_br_mispredict, i_br_rob_tag, i_br_target, i_rob_head, i_redirect_ready,
    input  o_branch_mispredict, o_mispredict_rob_tag, o_flush, o_stall_dispatch,
           o_redirect_valid, o_redirect_pc, o_recovery_count
  );

  modport slave (
    input  i_br_valid, i_br_mispredict, i_br_rob_tag, i_br_target, i_rob_head, i_redirect_ready,
    output o_branch_mispredict, o_mispredict_rob_tag, o_flush, o_stall_dispatch,
           o_redirect_valid, o_redirect_pc, o_recovery_count
  );
endinterface

// File: rtl/recovery_ctrl.sv
// Branch-mispredict recovery: oldest-first arbitration of mispredict reports, then
// FLUSH -> DRAIN -> REDIRECT with dispatch stalled, restarting on an older mispredict.

// Per-requester candidate qualification and age relative to the ROB head.
module recovery_ctrl_age #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 valid,
  input  logic                 mispredict,
  input  logic [ROB_WIDTH-1:0] tag,
  input  logic [ROB_WIDTH-1:0] head,
  output logic                 cand,
  output logic [ROB_WIDTH-1:0] age
);
  assign cand = valid & mispredict;
  assign age  = tag - head;
endmodule

module recovery_ctrl #(
  parameter int ROB_WIDTH    = 4,
  parameter int NUM_BR       = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  recovery_ctrl_if.slave bus
);
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, REDIRECT} state_t;

  state_t                           state, state_nxt;
  logic [ROB_WIDTH-1:0]             cur_tag, cur_tag_nxt;
  logic [31:0]                      cur_pc, cur_pc_nxt;
  logic [CW-1:0]                    drain_cnt, drain_cnt_nxt;
  logic [15:0]                      rec_cnt, rec_cnt_nxt;

  logic [NUM_BR-1:0][ROB_WIDTH-1:0] br_tag, br_age;
  logic [NUM_BR-1:0][31:0]          br_pc;
  logic [NUM_BR-1:0]                cand;
  logic                             win_found;
  logic [ROB_WIDTH-1:0]             win_age, win_tag, cur_age;
  logic [31:0]                      win_pc;
  logic                             preempt;

  assign br_tag = bus.i_br_rob_tag;
  assign br_pc  = bus.i_br_target;

  for (genvar k = 0; k < NUM_BR; k++) begin : g_lane
    recovery_ctrl_age #(.ROB_WIDTH(ROB_WIDTH)) u_age (
      .valid      (bus.i_br_valid[k]),
      .mispredict (bus.i_br_mispredict[k]),
      .tag        (br_tag[k]),
      .head       (bus.i_rob_head),
      .cand       (cand[k]),
      .age        (br_age[k])
    );
  end

  // Strict less-than keeps the lowest index on equal age.
  always_comb begin
    win_found = 1'b0;
    win_age   = '0;
    win_tag   = '0;
    win_pc    = '0;
    for (int k = 0; k < NUM_BR; k++) begin
      if (cand[k] && (!win_found || (br_age[k] < win_age))) begin
        win_found = 1'b1;
        win_age   = br_age[k];
        win_tag   = br_tag[k];
        win_pc    = br_pc[k];
      end
    end
  end

  // Both ages are re-taken against the live head so wrap-around compares correctly.
  assign cur_age = cur_tag - bus.i_rob_head;
  assign preempt = win_found && (win_age < cur_age);

  always_comb begin
    state_nxt     = state;
    cur_tag_nxt   = cur_tag;
    cur_pc_nxt    = cur_pc;
    drain_cnt_nxt = drain_cnt;
    rec_cnt_nxt   = rec_cnt;
    if (state == IDLE) begin
      if (win_found) begin
        state_nxt   = FLUSH;
        cur_tag_nxt = win_tag;
        cur_pc_nxt  = win_pc;
      end
    end else if (preempt) begin
      state_nxt   = FLUSH;
      cur_tag_nxt = win_tag;
      cur_pc_nxt  = win_pc;
    end else begin
      unique case (state)
        FLUSH: begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = CW'(DRAIN_CYCLES - 1);
        end
        DRAIN: begin
          if (drain_cnt == '0) state_nxt = REDIRECT;
          else                 drain_cnt_nxt = drain_cnt - 1'b1;
        end
        REDIRECT: begin
          if (bus.i_redirect_ready) begin
            state_nxt = IDLE;
            if (rec_cnt != 16'hFFFF) rec_cnt_nxt = rec_cnt + 16'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur_tag   <= '0;
      cur_pc    <= '0;
      drain_cnt <= '0;
      rec_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      cur_tag   <= cur_tag_nxt;
      cur_pc    <= cur_pc_nxt;
      drain_cnt <= drain_cnt_nxt;
      rec_cnt   <= rec_cnt_nxt;
    end
  end

  assign bus.o_branch_mispredict  = (state == FLUSH);
  assign bus.o_flush              = (state == FLUSH);
  assign bus.o_mispredict_rob_tag = cur_tag;
  assign bus.o_stall_dispatch     = (state != IDLE);
  assign bus.o_redirect_valid     = (state == REDIRECT);
  assign bus.o_redirect_pc        = cur_pc;
  assign bus.o_recovery_count     = rec_cnt;
endmodule

// File: tb/tb_recovery_ctrl.sv
// Scenario bench for recovery_ctrl: expected flushes/redirects are queued as stimulus
// is driven and retired by a monitor as the DUT produces them.
module tb_recovery_ctrl;
  localparam int RW = 4;
  localparam int NB = 2;
  localparam int DC = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;

  recovery_ctrl_if #(.ROB_WIDTH(RW), .NUM_BR(NB)) bus ();

  recovery_ctrl #(.ROB_WIDTH(RW), .NUM_BR(NB), .DRAIN_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [RW-1:0] tag;
    int            cyc;
  } flush_exp_t;

  flush_exp_t  flush_q[$];
  logic [31:0] redir_q[$];
  flush_exp_t  mon_fe;
  logic [31:0] mon_pc;

  // Monitor samples mid-cycle; inputs change just after the rising edge.
  always @(negedge clk) begin
    if (reset && bus.o_branch_mispredict) begin
      checks++;
      if (flush_q.size() == 0) begin
        errors++;
        $display("FAIL flush_unexpected: got tag=%0d at cyc=%0d, none expected", bus.o_mispredict_rob_tag, cyc);
      end else begin
        mon_fe = flush_q.pop_front();
        if (bus.o_mispredict_rob_tag !== mon_fe.tag || cyc != mon_fe.cyc || bus.o_flush !== 1'b1) begin
          errors++;
          $display("FAIL flush: got tag=%0d cyc=%0d flush=%b, expected tag=%0d cyc=%0d flush=1",
                   bus.o_mispredict_rob_tag, cyc, bus.o_flush, mon_fe.tag, mon_fe.cyc);
        end
      end
    end
    if (reset && bus.o_redirect_valid && bus.i_redirect_ready) begin
      checks++;
      if (redir_q.size() == 0) begin
        errors++;
        $display("FAIL redirect_unexpected: got pc=%h at cyc=%0d, none expected", bus.o_redirect_pc, cyc);
      end else begin
        mon_pc = redir_q.pop_front();
        if (bus.o_redirect_pc !== mon_pc) begin
          errors++;
          $display("FAIL redirect_pc: got %h, expected %h", bus.o_redirect_pc, mon_pc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input int k, input logic [RW-1:0] tag, input logic [31:0] pc, input logic mp);
    bus.i_br_valid[k]            = 1'b1;
    bus.i_br_mispredict[k]       = mp;
    bus.i_br_rob_tag[k*RW +: RW] = tag;
    bus.i_br_target[k*32 +: 32]  = pc;
  endtask

  task automatic clr_br();
    bus.i_br_valid      = '0;
    bus.i_br_mispredict = '0;
  endtask

  task automatic push_flush(input logic [RW-1:0] tag, input int at);
    flush_exp_t e;
    e.tag = tag;
    e.cyc = at;
    flush_q.push_back(e);
  endtask

  task automatic bump_count();
    exp_count = (exp_count == 65535) ? 65535 : exp_count + 1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.o_stall_dispatch && n < 40) begin
      step();
      n++;
    end
    if (bus.o_stall_dispatch) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: stall still high after %0d cycles, expected low", name, n);
    end
  endtask

  task automatic test_reset();
    bus.i_br_valid = '0; bus.i_br_mispredict = '0; bus.i_br_rob_tag = '0;
    bus.i_br_target = '0; bus.i_rob_head = '0; bus.i_redirect_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({bus.o_branch_mispredict, bus.o_flush, bus.o_stall_dispatch, bus.o_redirect_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got mp/flush/stall/rv=%b, expected 0000",
               {bus.o_branch_mispredict, bus.o_flush, bus.o_stall_dispatch, bus.o_redirect_valid});
    end
    checks++;
    if (bus.o_mispredict_rob_tag !== '0 || bus.o_redirect_pc !== '0) begin
      errors++;
      $display("FAIL reset_fields: got tag=%0d pc=%h, expected 0/0", bus.o_mispredict_rob_tag, bus.o_redirect_pc);
    end
    checks++;
    if (bus.o_recovery_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d, expected 0", bus.o_recovery_count);
    end
    step();
    step();
    reset = 1'b1;
    step();
    checks++;
    if (bus.o_stall_dispatch !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got stall=%b, expected 0", bus.o_stall_dispatch);
    end
  endtask

  task automatic test_single();
    int n0, stall_n, first_v;
    bus.i_rob_head = 4'd0;
    bus.i_redirect_ready = 1'b1;
    step();
    n0 = cyc;
    set_br(0, 4'd3, 32'h100, 1'b1);
    push_flush(4'd3, n0 + 1);
    redir_q.push_back(32'h100);
    bump_count();
    stall_n = 0;
    first_v = -1;
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j == 1) clr_br();
      if (bus.o_stall_dispatch) stall_n++;
      if (bus.o_redirect_valid && first_v < 0) first_v = cyc;
    end
    checks++;
    if (stall_n != 2 + DC) begin
      errors++;
      $display("FAIL single_stall_len: got %0d cycles, expected %0d", stall_n, 2 + DC);
    end
    checks++;
    if (first_v != n0 + 2 + DC) begin
      errors++;
      $display("FAIL single_redirect_cycle: got %0d, expected %0d", first_v, n0 + 2 + DC);
    end
    checks++;
    if (bus.o_recovery_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL single_count: got %0d, expected %0d", bus.o_recovery_count, exp_count);
    end
  endtask

  task automatic test_simultaneous();
    step();
    bus.i_rob_head = 4'd14;
    set_br(0, 4'd1, 32'hA0, 1'b1);
    set_br(1, 4'd15, 32'hB0, 1'b1);
    push_flush(4'd15, cyc + 1);
    redir_q.push_back(32'hB0);
    bump_count();
    step();
    clr_br();
    wait_idle("simul_wrap");
    step();
    set_br(0, 4'd5, 32'hC0, 1'b1);
    set_br(1, 4'd5, 32'hD0, 1'b1);
    push_flush(4'd5, cyc + 1);
    redir_q.push_back(32'hC0);
    bump_count();
    step();
    clr_br();
    wait_idle("simul_tie");
    checks++;
    if (bus.o_recovery_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL simul_count: got %0d, expected %0d", bus.o_recovery_count, exp_count);
    end
  endtask

  task automatic test_nested_older();
    int n0;
    step();
    bus.i_rob_head = 4'd2;
    n0 = cyc;
    set_br(0, 4'd6, 32'h600, 1'b1);
    push_flush(4'd6, n0 + 1);
    step();
    clr_br();
    step();
    set_br(1, 4'd4, 32'h400, 1'b1);
    push_flush(4'd4, n0 + 3);
    redir_q.push_back(32'h400);
    bump_count();
    step();
    clr_br();
    wait_idle("nested_older");
    checks++;
    if (bus.o_recovery_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL nested_older_count: got %0d, expected %0d", bus.o_recovery_count, exp_count);
    end
  endtask

  task automatic test_nested_younger();
    int n0;
    step();
    bus.i_rob_head = 4'd2;
    n0 = cyc;
    set_br(0, 4'd6, 32'h660, 1'b1);
    push_flush(4'd6, n0 + 1);
    redir_q.push_back(32'h660);
    bump_count();
    step();
    clr_br();
    step();
    set_br(1, 4'd9, 32'h990, 1'b1);
    step();
    clr_br();
    set_br(0, 4'd3, 32'h330, 1'b0);
    step();
    clr_br();
    set_br(1, 4'd3, 32'h331, 1'b0);
    checks++;
    if (bus.o_redirect_valid !== 1'b1 || bus.o_redirect_pc !== 32'h660 || cyc != n0 + 2 + DC) begin
      errors++;
      $display("FAIL younger_redirect: got rv=%b pc=%h cyc=%0d, expected rv=1 pc=00000660 cyc=%0d",
               bus.o_redirect_valid, bus.o_redirect_pc, cyc, n0 + 2 + DC);
    end
    step();
    clr_br();
    checks++;
    if (bus.o_stall_dispatch !== 1'b0 || bus.o_redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL younger_release: got stall=%b rv=%b, expected 0/0", bus.o_stall_dispatch, bus.o_redirect_valid);
    end
    checks++;
    if (bus.o_recovery_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL younger_count: got %0d, expected %0d", bus.o_recovery_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    step();
    bus.i_rob_head = 4'd0;
    bus.i_redirect_ready = 1'b0;
    set_br(0, 4'd7, 32'h700, 1'b1);
    push_flush(4'd7, cyc + 1);
    redir_q.push_back(32'h700);
    bump_count();
    step();
    clr_br();
    for (int j = 0; j < 1 + DC; j++) step();
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (bus.o_redirect_valid !== 1'b1 || bus.o_redirect_pc !== 32'h700 || bus.o_stall_dispatch !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rv=%b pc=%h stall=%b, expected rv=1 pc=00000700 stall=1",
                 j, bus.o_redirect_valid, bus.o_redirect_pc, bus.o_stall_dispatch);
      end
      step();
    end
    bus.i_redirect_ready = 1'b1;
    checks++;
    if (bus.o_redirect_valid !== 1'b1 || bus.o_stall_dispatch !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: got rv=%b stall=%b, expected 1/1", bus.o_redirect_valid, bus.o_stall_dispatch);
    end
    step();
    checks++;
    if (bus.o_redirect_valid !== 1'b0 || bus.o_stall_dispatch !== 1'b0 || bus.o_recovery_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL bp_done: got rv=%b stall=%b count=%0d, expected 0/0/%0d",
               bus.o_redirect_valid, bus.o_stall_dispatch, bus.o_recovery_count, exp_count);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    // Abort during DRAIN.
    step();
    bus.i_rob_head = 4'd0;
    bus.i_redirect_ready = 1'b1;
    set_br(0, 4'd5, 32'h500, 1'b1);
    push_flush(4'd5, cyc + 1);
    step();
    clr_br();
    step();
    #2 reset = 1'b0;
    #1;
    exp_count = 0;
    checks++;
    if ({bus.o_branch_mispredict, bus.o_flush, bus.o_stall_dispatch, bus.o_redirect_valid} !== 4'b0 ||
        bus.o_recovery_count !== 16'd0 || bus.o_redirect_pc !== '0 || bus.o_mispredict_rob_tag !== '0) begin
      errors++;
      $display("FAIL arst_drain: got ctrl=%b count=%0d pc=%h tag=%0d, expected all 0",
               {bus.o_branch_mispredict, bus.o_flush, bus.o_stall_dispatch, bus.o_redirect_valid},
               bus.o_recovery_count, bus.o_redirect_pc, bus.o_mispredict_rob_tag);
    end
    step();
    step();
    reset = 1'b1;
    bad = 0;
    for (int j = 0; j < 6; j++) begin
      step();
      if (bus.o_redirect_valid || bus.o_stall_dispatch) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL arst_drain_after: got %0d busy cycles, expected 0", bad);
    end
    // Abort during REDIRECT.
    bus.i_redirect_ready = 1'b0;
    set_br(0, 4'd6, 32'h600, 1'b1);
    push_flush(4'd6, cyc + 1);
    step();
    clr_br();
    for (int j = 0; j < 1 + DC; j++) step();
    checks++;
    if (bus.o_redirect_valid !== 1'b1 || bus.o_redirect_pc !== 32'h600) begin
      errors++;
      $display("FAIL arst_pre_redirect: got rv=%b pc=%h, expected 1/00000600", bus.o_redirect_valid, bus.o_redirect_pc);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.o_branch_mispredict, bus.o_flush, bus.o_stall_dispatch, bus.o_redirect_valid} !== 4'b0 ||
        bus.o_redirect_pc !== '0 || bus.o_recovery_count !== 16'd0) begin
      errors++;
      $display("FAIL arst_redirect: got ctrl=%b pc=%h count=%0d, expected all 0",
               {bus.o_branch_mispredict, bus.o_flush, bus.o_stall_dispatch, bus.o_redirect_valid},
               bus.o_redirect_pc, bus.o_recovery_count);
    end
    step();
    reset = 1'b1;
    bus.i_redirect_ready = 1'b1;
    bad = 0;
    for (int j = 0; j < 6; j++) begin
      step();
      if (bus.o_redirect_valid || bus.o_stall_dispatch) bad++;
    end
    checks++;
    if (bad != 0 || bus.o_recovery_count !== 16'd0) begin
      errors++;
      $display("FAIL arst_redirect_after: got %0d busy cycles count=%0d, expected 0/0", bad, bus.o_recovery_count);
    end
  endtask

  task automatic test_saturation();
    step();
    force dut.rec_cnt = 16'hFFFE;
    step();
    release dut.rec_cnt;
    exp_count = 65534;
    for (int r = 0; r < 2; r++) begin
      step();
      bus.i_rob_head = 4'd0;
      bus.i_redirect_ready = 1'b1;
      set_br(1, 4'd2, 32'h200 + r, 1'b1);
      push_flush(4'd2, cyc + 1);
      redir_q.push_back(32'h200 + r);
      bump_count();
      step();
      clr_br();
      wait_idle("sat");
      checks++;
      if (bus.o_recovery_count !== 16'(exp_count)) begin
        errors++;
        $display("FAIL sat_count[%0d]: got %h, expected %h", r, bus.o_recovery_count, exp_count);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_nested_older();
    test_nested_younger();
    test_backpressure();
    test_async_reset();
    test_saturation();
    step();
    step();
    checks++;
    if (flush_q.size() != 0) begin
      errors++;
      $display("FAIL flush_leftover: got %0d pending, expected 0", flush_q.size());
    end
    checks++;
    if (redir_q.size() != 0) begin
      errors++;
      $display("FAIL redirect_leftover: got %0d pending, expected 0", redir_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/recovery_ctrl.md
# recovery_ctrl

Branch-misprediction recovery controller between the branch-resolution units and the reorder buffer. Arbitrates same-cycle mispredict reports by program age relative to the ROB head, then sequences recovery:
- one-cycle ROB flush pulse;
- fixed dispatch-drain window;
- front-end PC redirect handshake.

Holds dispatch stalled for the whole sequence. Restarts cleanly if an older mispredict arrives mid-recovery.

## Interface
- ROB_WIDTH, 4, ROB tag width (ROB depth = 2^ROB_WIDTH)
- NUM_BR, 2, number of branch-resolution requesters
- DRAIN_CYCLES, 2, cycles spent in DRAIN (≥1)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserting (0) clears all state immediately
- i_br_valid  in  NUM_BR  requester k resolved a branch this cycle
- i_br_mispredict  in  NUM_BR  resolved branch k was mispredicted (ignored unless i_br_valid[k])
- i_br_rob_tag  in  NUM_BR*ROB_WIDTH  ROB tag of branch k, slice k at [k*ROB_WIDTH +: ROB_WIDTH]
- i_br_target  in  NUM_BR*32  correct PC for branch k, slice k at [k*32 +: 32]
- i_rob_head  in  ROB_WIDTH  current ROB head tag (ROB commit tag)
- o_branch_mispredict  out  1  one-cycle flush pulse to ROB
- o_mispredict_rob_tag  out  ROB_WIDTH  tag of the branch being recovered
- o_flush  out  1  one-cycle flush to RS/LSQ/rename, coincident with o_branch_mispredict
- o_stall_dispatch  out  1  blocks dispatch/ROB allocation
- o_redirect_valid  out  1  redirect request to fetch
- o_redirect_pc  out  32  redirect target
- i_redirect_ready  in  1  fetch accepts redirect
- o_recovery_count  out  16  saturating count of completed recoveries

## Operation
- States: IDLE, FLUSH, DRAIN, REDIRECT.
- Candidate k: i_br_valid[k] && i_br_mispredict[k].
- Age of candidate k: (tag_k − i_rob_head) mod 2^ROB_WIDTH, computed in ROB_WIDTH bits. Smaller age means older.
- Winner is the oldest candidate. On equal age, the lowest index wins.
- Registered fields: cur_tag, cur_pc.

**IDLE**
- On any candidate, capture the winner's tag and target, then go to FLUSH.
- Otherwise stay in IDLE.

**FLUSH** (exactly 1 cycle)
- o_branch_mispredict = o_flush = 1.
- o_mispredict_rob_tag = cur_tag.
- Next state: DRAIN, with drain counter loaded to DRAIN_CYCLES−1.

**DRAIN**
- Decrement the counter each cycle.
- At 0, go to REDIRECT.

**REDIRECT**
- o_redirect_valid = 1, o_redirect_pc = cur_pc.
- When i_redirect_ready = 1, go to IDLE and increment o_recovery_count (saturates at 0xFFFF).

**Stall**
- o_stall_dispatch = 1 in FLUSH, DRAIN and REDIRECT; 0 in IDLE.

**Nested mispredict** (in DRAIN or REDIRECT)
- Compare the winner's age against cur_tag's age, both taken relative to the current i_rob_head.
- If strictly older: recapture the winner and go to FLUSH. Any pending redirect is abandoned and the count is not incremented.
- If younger or equal: ignore it; that branch is already flushed.

**Nested mispredict** (in FLUSH)
- Handled identically: an older winner re-enters FLUSH on the next cycle.

**Ignored inputs**
- Correctly predicted resolutions (i_br_mispredict = 0) are always ignored.

## Timing
- Reset values: state IDLE; every output 0, including o_mispredict_rob_tag, o_redirect_pc and o_recovery_count; internal tag/pc/counter 0.
- All outputs are decoded from registered state and fields; there is no combinational input-to-output path.
- Reset mid-recovery aborts immediately to IDLE. No redirect is issued.
- Mispredict sampled in cycle N:
  - FLUSH pulse in N+1;
  - DRAIN in N+2 … N+1+DRAIN_CYCLES;
  - o_redirect_valid from N+2+DRAIN_CYCLES.
- Redirect handshake:
  - Redirect transfers on a cycle where o_redirect_valid && i_redirect_ready.
  - o_redirect_valid and o_redirect_pc stay stable until the transfer.
  - o_stall_dispatch drops the cycle after the transfer.
- Ready asserted in the first REDIRECT cycle gives a minimum recovery of 2+DRAIN_CYCLES cycles of stall.
- A new mispredict sampled in the handshake cycle is handled as follows:
  - If older than cur_tag, it takes priority: go to FLUSH and the redirect is not counted.
  - Otherwise the handshake completes and the new report is ignored.
- Age arithmetic wraps modulo 2^ROB_WIDTH. Example: with head=14, tag 1 (age 3) is older than tag 15? No: tag 15 has age 1 and is older; tag 1 has age 3.

## Test plan
- Single mispredict: reset released, head=0, br0 tag=3, target=0x100 for 1 cycle, ready=1.
  - Expect one-cycle o_branch_mispredict with tag 3 at N+1.
  - Expect stall for 4 cycles, redirect 0x100 at N+4, count=1.
- Simultaneous reports: head=14, br0 tag=1 target=0xA0, br1 tag=15 target=0xB0.
  - Expect flush tag 15 and redirect 0xB0 (wrap age).
  - Repeat with equal tags: br0 wins.
- Nested older mispredict: first br0 tag=6; during DRAIN, br1 tag=4 (head=2).
  - Expect a second FLUSH pulse with tag 4 and redirect to br1's target.
  - Expect exactly one count increment.
- Nested younger mispredict and correct predictions: during DRAIN, tag 9 (cur_tag 6, head 2), then i_br_mispredict=0 reports.
  - Expect no extra flush and unchanged timing.
- Backpressure: hold i_redirect_ready=0 for 5 cycles in REDIRECT.
  - Expect o_redirect_valid and o_redirect_pc stable and stall held.
  - Expect a single accept on ready.
- Async reset: drop reset mid-DRAIN and mid-REDIRECT.
  - Expect all outputs 0 immediately, without a clock edge.
  - Expect no redirect after release; o_recovery_count saturation checked at 0xFFFF.
